spec_demux: RTL and testbench



---
 rtl/spec_demux_pkg.sv | 10 +
 rtl/spec_guard_cnt.sv | 28 ++
 rtl/spec_demux.sv | 127 ++++++++++++
 tb/tb_spec_demux.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/spec_demux_pkg.sv
// Shared encodings and widths for the glitch-free 1-to-2 demultiplexer.
package spec_demux_pkg;

    localparam logic [1:0] ST_ROUTE0 = 2'b00;
    localparam logic [1:0] ST_GUARD  = 2'b01;
    localparam logic [1:0] ST_ROUTE1 = 2'b10;

    localparam int GCNT_W = 4;

endpackage

// File: rtl/spec_guard_cnt.sv
// Loadable down-counter timing the dead interval after a route change.
import spec_demux_pkg::*;

module spec_guard_cnt (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [GCNT_W-1:0] load_val,
    input  logic              dec,
    output logic              zero
);

    logic [GCNT_W-1:0] r_cnt;

    // Load has priority over decrement; a restart must win over a count step.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule

// File: rtl/spec_demux.sv
// Registered 1-to-2 demultiplexer with a guard interval on every route change.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_ROUTE0  | data steered to channel 0 while sel == 0
// ST_GUARD   | both channels idle, waiting for sel to settle on r_target
// ST_ROUTE1  | data steered to channel 1 while sel == 1
import spec_demux_pkg::*;

module spec_demux #(
    parameter int WIDTH = 1,
    parameter int GUARD = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    input  logic             sel,
    output logic [WIDTH-1:0] out0,
    output logic             out0_valid,
    output logic [WIDTH-1:0] out1,
    output logic             out1_valid,
    output logic             busy
);

    // GUARD == 0 never loads the counter, so its reload value is irrelevant there.
    localparam logic [GCNT_W-1:0] GUARD_RELOAD =
        (GUARD == 0) ? '0 : GCNT_W'(GUARD - 1);

    logic [1:0]       r_state;
    logic             r_target;
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;
    logic             r_out0_valid;
    logic             r_out1_valid;

    logic [1:0]       w_next_state;
    logic             w_load;
    logic             w_dec;
    logic             w_zero;
    logic             w_in_route;
    logic             w_route_n;
    logic             w_mismatch;

    assign w_in_route = (r_state == ST_ROUTE0) || (r_state == ST_ROUTE1);
    assign w_route_n  = (r_state == ST_ROUTE1);
    assign w_mismatch = w_in_route && (sel != w_route_n);
    assign busy       = (r_state == ST_GUARD) || w_mismatch;

    spec_guard_cnt u_guard_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (GUARD_RELOAD),
        .dec      (w_dec),
        .zero     (w_zero)
    );

    // Next-state and guard-counter control.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            ST_ROUTE0, ST_ROUTE1: begin
                if (sel != w_route_n) begin
                    if (GUARD != 0) begin
                        w_next_state = ST_GUARD;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = sel ? ST_ROUTE1 : ST_ROUTE0;
                    end
                end
            end
            ST_GUARD: begin
                if (sel != r_target) begin
                    w_load = 1'b1;
                end else if (w_zero) begin
                    w_next_state = r_target ? ST_ROUTE1 : ST_ROUTE0;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_next_state = ST_ROUTE0;
        endcase
    end

    // State and pending-route registers; every guard (re)start captures sel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_ROUTE0;
            r_target <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_target <= sel;
            end
        end
    end

    // Output registers: only the channel owning a stable route may update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out0       <= '0;
            r_out1       <= '0;
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
        end else begin
            r_out0_valid <= 1'b0;
            r_out1_valid <= 1'b0;
            if ((r_state == ST_ROUTE0) && !sel && data_valid) begin
                r_out0       <= data_in;
                r_out0_valid <= 1'b1;
            end
            if ((r_state == ST_ROUTE1) && sel && data_valid) begin
                r_out1       <= data_in;
                r_out1_valid <= 1'b1;
            end
        end
    end

    assign out0       = r_out0;
    assign out0_valid = r_out0_valid;
    assign out1       = r_out1;
    assign out1_valid = r_out1_valid;

endmodule

// File: tb/tb_spec_demux.sv
// Bench for spec_demux: three instances (GUARD = 2, 0, 3) share stimulus,
// each table targets one of them.
module tb_spec_demux;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       sel;

    logic [7:0] w_o0 [3];
    logic [7:0] w_o1 [3];
    logic       w_v0 [3];
    logic       w_v1 [3];
    logic       w_busy [3];

    always #5 clk = ~clk;

    spec_demux #(.WIDTH(8), .GUARD(2)) u_g2 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .sel(sel),
        .out0(w_o0[0]), .out0_valid(w_v0[0]), .out1(w_o1[0]), .out1_valid(w_v1[0]),
        .busy(w_busy[0]));

    spec_demux #(.WIDTH(8), .GUARD(0)) u_g0 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .sel(sel),
        .out0(w_o0[1]), .out0_valid(w_v0[1]), .out1(w_o1[1]), .out1_valid(w_v1[1]),
        .busy(w_busy[1]));

    spec_demux #(.WIDTH(8), .GUARD(3)) u_g3 (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .sel(sel),
        .out0(w_o0[2]), .out0_valid(w_v0[2]), .out1(w_o1[2]), .out1_valid(w_v1[2]),
        .busy(w_busy[2]));

    typedef struct {
        logic       rst;
        logic       sel;
        logic       dv;
        logic [7:0] data;
        logic       busy;
        logic       v0;
        logic [7:0] o0;
        logic       v1;
        logic [7:0] o1;
    } vec_t;

    typedef struct {
        logic       v0;
        logic [7:0] o0;
        logic       v1;
        logic [7:0] o1;
        int         row;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic add(input logic r, input logic s, input logic d, input logic [7:0] dat,
                       input logic b, input logic v0, input logic [7:0] o0,
                       input logic v1, input logic [7:0] o1);
        vec_t v;
        v.rst = r; v.sel = s; v.dv = d; v.data = dat; v.busy = b;
        v.v0 = v0; v.o0 = o0; v.v1 = v1; v.o1 = o1;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sel = 1'b0; data_valid = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset[%0d].out0", k),       w_o0[k], 8'h00);
            check($sformatf("reset[%0d].out1", k),       w_o1[k], 8'h00);
            check($sformatf("reset[%0d].out0_valid", k), 8'(w_v0[k]), 8'h00);
            check($sformatf("reset[%0d].out1_valid", k), 8'(w_v1[k]), 8'h00);
            check($sformatf("reset[%0d].busy", k),       8'(w_busy[k]), 8'h00);
        end
    endtask

    // Each row: drive at the falling edge, check busy, queue the post-edge outputs.
    task automatic run(input int k, input string name);
        exp_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; sel = tbl[i].sel;
            data_valid = tbl[i].dv; data_in = tbl[i].data;
            #1;
            check($sformatf("%s[%0d].busy", name, i), 8'(w_busy[k]), 8'(tbl[i].busy));
            e.v0 = tbl[i].v0; e.o0 = tbl[i].o0; e.v1 = tbl[i].v1; e.o1 = tbl[i].o1; e.row = i;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("%s[%0d].scoreboard_empty", name, i), 8'h01, 8'h00);
            end else begin
                e = sb.pop_front();
                check($sformatf("%s[%0d].out0_valid", name, e.row), 8'(w_v0[k]), 8'(e.v0));
                check($sformatf("%s[%0d].out0", name, e.row),       w_o0[k], e.o0);
                check($sformatf("%s[%0d].out1_valid", name, e.row), 8'(w_v1[k]), 8'(e.v1));
                check($sformatf("%s[%0d].out1", name, e.row),       w_o1[k], e.o1);
            end
        end
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; data_valid = 1'b0; data_in = 8'h00;

        // Stream on channel 0, then route change with GUARD = 2 (change in cycle 5).
        do_reset();
        //   rst sel dv data   busy v0 o0     v1 o1
        add(0, 0, 1, 8'h11, 0, 1, 8'h11, 0, 8'h00);
        add(0, 0, 1, 8'h22, 0, 1, 8'h22, 0, 8'h00);
        add(0, 0, 1, 8'h33, 0, 1, 8'h33, 0, 8'h00);
        add(0, 0, 0, 8'h99, 0, 0, 8'h33, 0, 8'h00);
        add(0, 0, 1, 8'h44, 0, 1, 8'h44, 0, 8'h00);
        add(0, 1, 1, 8'hAA, 1, 0, 8'h44, 0, 8'h00);
        add(0, 1, 1, 8'h55, 1, 0, 8'h44, 0, 8'h00);
        add(0, 1, 1, 8'h66, 1, 0, 8'h44, 0, 8'h00);
        add(0, 1, 1, 8'hBB, 0, 0, 8'h44, 1, 8'hBB);
        add(0, 1, 1, 8'hCC, 0, 0, 8'h44, 1, 8'hCC);
        add(0, 1, 0, 8'h77, 0, 0, 8'h44, 0, 8'hCC);
        add(0, 0, 1, 8'hDD, 1, 0, 8'h44, 0, 8'hCC);
        add(0, 0, 1, 8'hDE, 1, 0, 8'h44, 0, 8'hCC);
        add(0, 0, 1, 8'hDF, 1, 0, 8'h44, 0, 8'hCC);
        add(0, 0, 1, 8'hEE, 0, 1, 8'hEE, 0, 8'hCC);
        run(0, "g2_route");

        // GUARD = 0: only the change cycle is dropped.
        do_reset();
        add(0, 0, 1, 8'h01, 0, 1, 8'h01, 0, 8'h00);
        add(0, 0, 1, 8'h02, 0, 1, 8'h02, 0, 8'h00);
        add(0, 0, 1, 8'h03, 0, 1, 8'h03, 0, 8'h00);
        add(0, 1, 1, 8'h04, 1, 0, 8'h03, 0, 8'h00);
        add(0, 1, 1, 8'h05, 0, 0, 8'h03, 1, 8'h05);
        add(0, 1, 1, 8'h06, 0, 0, 8'h03, 1, 8'h06);
        add(0, 0, 1, 8'h07, 1, 0, 8'h03, 0, 8'h06);
        add(0, 0, 1, 8'h08, 0, 1, 8'h08, 0, 8'h06);
        run(1, "g0_direct");

        // GUARD = 3: sel glitch 0->1 in cycle 4, back in cycle 5; channel 0 resumes in cycle 9.
        do_reset();
        add(0, 0, 1, 8'h10, 0, 1, 8'h10, 0, 8'h00);
        add(0, 0, 1, 8'h11, 0, 1, 8'h11, 0, 8'h00);
        add(0, 0, 1, 8'h12, 0, 1, 8'h12, 0, 8'h00);
        add(0, 0, 1, 8'h13, 0, 1, 8'h13, 0, 8'h00);
        add(0, 1, 1, 8'h14, 1, 0, 8'h13, 0, 8'h00);
        add(0, 0, 1, 8'h15, 1, 0, 8'h13, 0, 8'h00);
        add(0, 0, 1, 8'h16, 1, 0, 8'h13, 0, 8'h00);
        add(0, 0, 1, 8'h17, 1, 0, 8'h13, 0, 8'h00);
        add(0, 0, 1, 8'h18, 1, 0, 8'h13, 0, 8'h00);
        add(0, 0, 1, 8'h19, 0, 1, 8'h19, 0, 8'h00);
        add(0, 0, 1, 8'h1A, 0, 1, 8'h1A, 0, 8'h00);
        run(2, "g3_glitch");

        // GUARD = 2: reset in the second guard cycle, then ROUTE0 accepts immediately.
        do_reset();
        add(0, 0, 1, 8'h21, 0, 1, 8'h21, 0, 8'h00);
        add(0, 1, 1, 8'h22, 1, 0, 8'h21, 0, 8'h00);
        add(0, 1, 1, 8'h24, 1, 0, 8'h21, 0, 8'h00);
        add(1, 1, 1, 8'h25, 1, 0, 8'h00, 0, 8'h00);
        add(0, 0, 1, 8'h23, 0, 1, 8'h23, 0, 8'h00);
        add(0, 1, 1, 8'h26, 1, 0, 8'h23, 0, 8'h00);
        run(0, "g2_rst_guard");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
